led_rx: RTL and testbench

Single-wire LED stream receiver: the receive end of the one-wire NRZ pixel protocol our serializer drives on LED_OUT. It samples an asynchronous LED data input and measures high-pulse widths against programmable thresholds. It assembles MSB-first 24- or 32-bit pixels, hands them out over a valid/ready port, and flags end-of-frame on a reset code. It is used for loopback self-test and for daisy-chain monitoring.

---
 rtl/led_pkg.sv | 24 ++
 rtl/led_rx_sync.sv | 57 +++++
 rtl/led_rx.sv | 228 ++++++++++++++++++++++
 tb/tb_led_rx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared constants for the single-wire LED stream receiver: FSM encoding,
// pixel format codes, reset-code scaling and bits-per-pixel helpers.
package led_pkg;

  // Receiver FSM encoding
  localparam logic [1:0] StWaitRst = 2'd0;
  localparam logic [1:0] StLow     = 2'd1;
  localparam logic [1:0] StHigh    = 2'd2;

  // FORMAT input encodings
  localparam logic FMT_24 = 1'b0;
  localparam logic FMT_32 = 1'b1;

  // Reset code length = max(RESET_CODE_TIMING,1) << RST_SCALE_SHIFT clocks
  localparam int unsigned RST_SCALE_SHIFT = 6;

  localparam logic [5:0] BITS_24 = 6'd24;
  localparam logic [5:0] BITS_32 = 6'd32;

  function automatic logic [5:0] pixel_bits(input logic fmt);
    return (fmt == FMT_24) ? BITS_24 : BITS_32;
  endfunction

endpackage

// File: rtl/led_rx_sync.sv
// Input conditioning for the LED receiver: 2-FF synchronizer, optional
// 3-sample majority filter (LED_RX_GLITCH_FILTER_EN), and edge strobes.
module led_rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q, s2_q, prev_q, level;

  // Two-stage synchronizer for the asynchronous input
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

`ifdef LED_RX_GLITCH_FILTER_EN
  logic s3_q, s4_q;

  // Sample history for the majority vote; a level needs two agreeing samples
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s3_q <= 1'b0;
      s4_q <= 1'b0;
    end else begin
      s3_q <= s2_q;
      s4_q <= s3_q;
    end
  end

  assign level = (s2_q & s3_q) | (s2_q & s4_q) | (s3_q & s4_q);
`else
  assign level = s2_q;
`endif

  // Previous conditioned level, for edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level;
    end
  end

  assign level_o = level;
  assign rise_o  = level & ~prev_q;
  assign fall_o  = ~level & prev_q;

endmodule

// File: rtl/led_rx.sv
// Single-wire NRZ LED stream receiver. Measures synchronized high/low widths,
// decodes MSB-first 24/32-bit pixels onto a valid/ready port and flags EOF on
// a reset code. Optional input majority filter: LED_RX_GLITCH_FILTER_EN.
module led_rx
  import led_pkg::*;
#(
  parameter int unsigned CntW = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        enable_i,
  input  logic        format_i,
  input  logic [7:0]  bit_thresh_i,
  input  logic [7:0]  min_high_i,
  input  logic [7:0]  reset_code_timing_i,
  input  logic        led_in_i,
  output logic [31:0] pixel_data_o,
  output logic        pixel_valid_o,
  input  logic        pixel_ready_i,
  output logic        eof_o,
  output logic        overflow_o,
  output logic        error_o,
  input  logic        error_clr_i,
  output logic [15:0] pixel_count_o
);

  logic lvl, rise, fall;

  led_rx_sync u_sync (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .d_i     (led_in_i),
    .level_o (lvl),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] hcnt_q, hcnt_d, lcnt_q, lcnt_d;
  logic [30:0]     shreg_q, shreg_d;
  logic [5:0]      bitcnt_q, bitcnt_d;
  logic            fmt_q, fmt_d;
  logic [31:0]     data_q, data_d;
  logic            valid_q, valid_d, eof_q, eof_d, ovf_q, ovf_d, err_q, err_d;
  logic [15:0]     count_q, count_d;
  // seen: a bit arrived since the last frame end; pend: clear count on next rise
  logic            seen_q, seen_d, pend_q, pend_d;

  logic [7:0]      rct_eff;
  logic [CntW-1:0] thr_m1;
  logic            bit_in, cur_fmt, complete, err_set;
  logic [31:0]     shifted, pix;

  function automatic logic [CntW-1:0] sat_inc(input logic [CntW-1:0] v);
    return (&v) ? v : v + CntW'(1);
  endfunction

  assign rct_eff = (reset_code_timing_i == 8'd0) ? 8'd1 : reset_code_timing_i;
  // Compare against threshold-1 so the count hits it on the threshold-th cycle
  assign thr_m1  = CntW'(32'(rct_eff) << RST_SCALE_SHIFT) - CntW'(1);
  assign bit_in  = (hcnt_q >= CntW'(bit_thresh_i));
  assign cur_fmt = (bitcnt_q == 6'd0) ? format_i : fmt_q;
  assign shifted = {shreg_q, bit_in};
  assign pix     = (cur_fmt == FMT_32) ? shifted : {8'h00, shifted[23:0]};

  // Width measurement, bit decode, pixel hand-off and status flags
  always_comb begin
    state_d  = state_q;
    hcnt_d   = hcnt_q;
    lcnt_d   = lcnt_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    fmt_d    = fmt_q;
    data_d   = data_q;
    valid_d  = valid_q;
    count_d  = count_q;
    seen_d   = seen_q;
    pend_d   = pend_q;
    eof_d    = 1'b0;
    ovf_d    = 1'b0;
    complete = 1'b0;
    err_set  = 1'b0;

    if (valid_q && pixel_ready_i) valid_d = 1'b0;

    unique case (state_q)
      StWaitRst: begin
        if (lvl) begin
          lcnt_d = '0;
        end else begin
          lcnt_d = sat_inc(lcnt_q);
          if (lcnt_q == thr_m1) begin
            state_d = StLow;
            seen_d  = 1'b0;
            pend_d  = 1'b1;
          end
        end
      end
      StLow: begin
        if (rise) begin
          state_d = StHigh;
          hcnt_d  = CntW'(1);
          if (pend_q) begin
            count_d = '0;
            pend_d  = 1'b0;
          end
        end else if (!lvl) begin
          lcnt_d = sat_inc(lcnt_q);
          if (lcnt_q == thr_m1) begin
            eof_d    = seen_q;
            err_set  = (bitcnt_q != 6'd0);
            bitcnt_d = '0;
            shreg_d  = '0;
            seen_d   = 1'b0;
            pend_d   = 1'b1;
          end
        end
      end
      StHigh: begin
        if (fall) begin
          lcnt_d = CntW'(1);
          if (hcnt_q < CntW'(min_high_i)) begin
            err_set  = 1'b1;
            bitcnt_d = '0;
            shreg_d  = '0;
            state_d  = StWaitRst;
          end else begin
            state_d = StLow;
            seen_d  = 1'b1;
            if (bitcnt_q == 6'd0) fmt_d = format_i;
            if (bitcnt_q + 6'd1 == pixel_bits(cur_fmt)) begin
              complete = 1'b1;
              bitcnt_d = '0;
              shreg_d  = '0;
            end else begin
              bitcnt_d = bitcnt_q + 6'd1;
              shreg_d  = shifted[30:0];
            end
          end
        end else if (lvl) begin
          if (hcnt_q == thr_m1) begin
            // Line stuck high
            err_set  = 1'b1;
            bitcnt_d = '0;
            shreg_d  = '0;
            lcnt_d   = '0;
            state_d  = StWaitRst;
          end else begin
            hcnt_d = sat_inc(hcnt_q);
          end
        end
      end
      default: state_d = StWaitRst;
    endcase

    if (complete) begin
      if (!valid_q || pixel_ready_i) begin
        data_d  = pix;
        valid_d = 1'b1;
        count_d = (&count_q) ? count_q : count_q + 16'd1;
      end else begin
        ovf_d   = 1'b1;
        err_set = 1'b1;
      end
    end

    // Set wins over clear
    err_d = err_set | (err_q & ~error_clr_i);

    if (!enable_i) begin
      state_d  = StWaitRst;
      hcnt_d   = '0;
      lcnt_d   = '0;
      shreg_d  = '0;
      bitcnt_d = '0;
      count_d  = '0;
      valid_d  = 1'b0;
      seen_d   = 1'b0;
      pend_d   = 1'b0;
      eof_d    = 1'b0;
      ovf_d    = 1'b0;
      err_d    = err_q & ~error_clr_i;
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StWaitRst;
      hcnt_q   <= '0;
      lcnt_q   <= '0;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      fmt_q    <= FMT_24;
      data_q   <= '0;
      valid_q  <= 1'b0;
      eof_q    <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      count_q  <= '0;
      seen_q   <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hcnt_q   <= hcnt_d;
      lcnt_q   <= lcnt_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      fmt_q    <= fmt_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      eof_q    <= eof_d;
      ovf_q    <= ovf_d;
      err_q    <= err_d;
      count_q  <= count_d;
      seen_q   <= seen_d;
      pend_q   <= pend_d;
    end
  end

  assign pixel_data_o  = data_q;
  assign pixel_valid_o = valid_q;
  assign eof_o         = eof_q;
  assign overflow_o    = ovf_q;
  assign error_o       = err_q;
  assign pixel_count_o = count_q;

endmodule

// File: tb/tb_led_rx.sv
// Directed self-checking bench for led_rx (default build, no input filter).
module tb_led_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, format, led, ready, error_clr;
  logic [7:0]  bit_thresh, min_high, rct;
  logic [31:0] pixel_data;
  logic        pixel_valid, eof, overflow, error;
  logic [15:0] pixel_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fall = 0;
  int valid_rises = 0, valid_cyc = 0, eof_n = 0, eof_cyc = 0, ovf_n = 0;
  logic prev_valid = 1'b0;
  int s_valid, s_eof, s_ovf;

  localparam int ThrClk = 40 * 64;

  led_rx #(.CntW(16)) dut (
    .clk_i               (clk),
    .rst_ni              (rst_n),
    .enable_i            (enable),
    .format_i            (format),
    .bit_thresh_i        (bit_thresh),
    .min_high_i          (min_high),
    .reset_code_timing_i (rct),
    .led_in_i            (led),
    .pixel_data_o        (pixel_data),
    .pixel_valid_o       (pixel_valid),
    .pixel_ready_i       (ready),
    .eof_o               (eof),
    .overflow_o          (overflow),
    .error_o             (error),
    .error_clr_i         (error_clr),
    .pixel_count_o       (pixel_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder, sampled on the falling edge
  always @(negedge clk) begin
    prev_valid <= pixel_valid;
    if (pixel_valid && !prev_valid) begin
      valid_rises <= valid_rises + 1;
      valid_cyc   <= cyc;
    end
    if (eof) begin
      eof_n   <= eof_n + 1;
      eof_cyc <= cyc;
    end
    if (overflow) ovf_n <= ovf_n + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    led = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input int hi, input int lo);
    led = 1'b1;
    repeat (hi) @(negedge clk);
    led = 1'b0;
    last_fall = cyc;
    repeat (lo) @(negedge clk);
  endtask

  task automatic send_std(input logic b);
    if (b) send_bit(28, 12);
    else   send_bit(14, 26);
  endtask

  task automatic send_word(input logic [31:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) send_std(w[i]);
  endtask

  task automatic snap();
    s_valid = valid_rises;
    s_eof   = eof_n;
    s_ovf   = ovf_n;
  endtask

  task automatic clr_error();
    error_clr = 1'b1;
    @(negedge clk);
    error_clr = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; format = 1'b0; led = 1'b0; ready = 1'b1;
    error_clr = 1'b0; bit_thresh = 8'd20; min_high = 8'd4; rct = 8'd40;
    repeat (3) @(negedge clk);
    check("reset_outputs", {pixel_data, pixel_valid, eof, overflow, error, pixel_count}, 64'd0);
    rst_n = 1'b1;

    // 1: single 24-bit pixel, consumer ready
    idle(3000);
    snap();
    send_word(32'h00A5C3F0, 24);
    idle(3000);
    check("t1_data", pixel_data, 64'h00A5C3F0);
    check("t1_valid_lat", 64'(valid_cyc - last_fall), 64'd3);
    check("t1_valid_cnt", 64'(valid_rises - s_valid), 64'd1);
    check("t1_eof_lat", 64'(eof_cyc - last_fall), 64'(ThrClk + 2));
    check("t1_eof_cnt", 64'(eof_n - s_eof), 64'd1);
    check("t1_count", pixel_count, 64'd1);
    check("t1_error", error, 64'd0);
    check("t1_valid_consumed", pixel_valid, 64'd0);

    // 2: 32-bit pixels with consumer stalled -> overflow on the second
    format = 1'b1; ready = 1'b0;
    snap();
    send_word(32'h11223344, 32);
    send_word(32'h55667788, 32);
    idle(50);
    check("t2_ovf_cnt", 64'(ovf_n - s_ovf), 64'd1);
    check("t2_error", error, 64'd1);
    check("t2_data", pixel_data, 64'h11223344);
    check("t2_valid", pixel_valid, 64'd1);
    check("t2_count", pixel_count, 64'd1);
    idle(3000);
    check("t2_eof_cnt", 64'(eof_n - s_eof), 64'd1);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    @(negedge clk);
    check("t2_handshake", pixel_valid, 64'd0);
    clr_error();
    check("t2_err_clr", error, 64'd0);

    // 3: glitch mid-pixel forces resync
    format = 1'b0; ready = 1'b1;
    snap();
    send_word(32'h0000001F, 5);
    send_bit(2, 26);
    send_word(32'h0007FFFF, 19);
    check("t3_error", error, 64'd1);
    check("t3_no_valid", 64'(valid_rises - s_valid), 64'd0);
    idle(3000);
    check("t3_no_eof", 64'(eof_n - s_eof), 64'd0);
    send_word(32'h00123456, 24);
    idle(3000);
    check("t3_data", pixel_data, 64'h00123456);
    check("t3_valid_cnt", 64'(valid_rises - s_valid), 64'd1);
    check("t3_eof_cnt", 64'(eof_n - s_eof), 64'd1);

    // 4: partial pixel then reset code
    clr_error();
    check("t4_err_clr", error, 64'd0);
    snap();
    send_word(32'h000002CB, 10);
    idle(3000);
    check("t4_eof_cnt", 64'(eof_n - s_eof), 64'd1);
    check("t4_error", error, 64'd1);
    check("t4_no_valid", 64'(valid_rises - s_valid), 64'd0);
    check("t4_count", pixel_count, 64'd0);

    // 5: exact threshold boundary, 20 -> '1', 19 -> '0'
    clr_error();
    for (int i = 0; i < 24; i++) send_bit((i % 2 == 0) ? 20 : 19, 20);
    idle(3000);
    check("t5_data", pixel_data, 64'h00AAAAAA);
    check("t5_error", error, 64'd0);

    // 6: enable drop mid-pixel, then async reset mid-frame
    snap();
    send_word(32'h00000FFF, 12);
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    send_word(32'h00000ABC, 12);
    idle(100);
    check("t6_no_valid", 64'(valid_rises - s_valid), 64'd0);
    check("t6_error", error, 64'd0);
    check("t6_data_kept", pixel_data, 64'h00AAAAAA);
    check("t6_count", pixel_count, 64'd0);
    idle(3000);
    send_word(32'h00ABCDEF, 24);
    idle(200);
    check("t6_data", pixel_data, 64'h00ABCDEF);
    check("t6_count_after", pixel_count, 64'd1);
    send_word(32'h000000FF, 8);
    led = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("t6_async_rst", {pixel_data, pixel_valid, eof, overflow, error, pixel_count},
             64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    led = 1'b0;
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
